// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage that sits directly upstream of a small
//   combinational-read RAM. It owns the program counter (PC) and the memory
//   address register (MAR), drives the RAM address, and captures the returned
//   byte into the instruction register (IR). The IR is handed to the decoder
//   over a VALID/READY handshake. Jump and halt requests from the decoder are
//   applied only when an instruction is accepted.
//
//   Fetch sequence: IDLE -> ADDR (MAR<=PC) -> DATA (IR<=ram, PC++) -> ISSUE.
//   This gives at most one instruction every three cycles.
//
// Ports
//   CLK          in   1       system clock, rising edge
//   RST          in   1       synchronous reset, active-high
//   RUN          in   1       leave IDLE and start fetching (level, IDLE only)
//   RAM_DATA     in   DATA_W  RAM read data for RAM_ADDRESS
//   INSTR_READY  in   1       decoder accepts INSTR this cycle
//   JUMP         in   1       redirect PC on handshake
//   JUMP_ADDR    in   ADDR_W  absolute jump target
//   HALT_REQ     in   1       stop fetching on handshake (wins over JUMP)
//   RAM_ADDRESS  out  ADDR_W  registered MAR
//   RAM_OPCODE   out  1       always 0 (read); this block never writes
//   INSTR        out  DATA_W  registered IR
//   INSTR_VALID  out  1       IR holds an instruction awaiting the decoder
//   PC_OUT       out  ADDR_W  current PC
//   HALTED       out  1       fetch stopped until reset
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  input  logic [DATA_W-1:0] RAM_DATA,
  input  logic              INSTR_READY,
  input  logic              JUMP,
  input  logic [ADDR_W-1:0] JUMP_ADDR,
  input  logic              HALT_REQ,
  output logic [ADDR_W-1:0] RAM_ADDRESS,
  output logic              RAM_OPCODE,
  output logic [DATA_W-1:0] INSTR,
  output logic              INSTR_VALID,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              HALTED
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic              valid_q;
  logic              halted_q;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others (e.g. MAR<=PC and a
  // PC update never race).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      pc       <= '0;
      mar      <= '0;
      ir       <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (RUN) state <= S_ADDR;
        end
        S_ADDR: begin
          mar   <= pc;
          state <= S_DATA;
        end
        S_DATA: begin
          // RAM read is combinational on MAR, so the byte is ready now.
          ir      <= RAM_DATA;
          pc      <= pc + 1'b1;  // wraps modulo 2**ADDR_W
          valid_q <= 1'b1;
          state   <= S_ISSUE;
        end
        S_ISSUE: begin
          // valid_q is high throughout ISSUE, so READY alone is the handshake.
          if (INSTR_READY) begin
            valid_q <= 1'b0;
            if (HALT_REQ) begin
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else begin
              if (JUMP) pc <= JUMP_ADDR;
              state <= S_ADDR;
            end
          end
        end
        S_HALT: begin
          // Terminal: only RST leaves this state.
        end
        default: begin
          state    <= S_IDLE;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign RAM_ADDRESS = mar;
  assign RAM_OPCODE  = 1'b0;
  assign INSTR       = ir;
  assign INSTR_VALID = valid_q;
  assign PC_OUT      = pc;
  assign HALTED      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A bench-side RAM feeds RAM_DATA from
//   RAM_ADDRESS. A reference model tracks the fetch stream as "edges until the
//   next instruction is valid" plus PC/MAR/IR values, and every cycle the DUT
//   outputs are compared against it. A directed vector table, hand-written
//   corner sequences and a randomized run all share that per-cycle compare.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              CLK;
  logic              RST;
  logic              RUN;
  logic [DATA_W-1:0] RAM_DATA;
  logic              INSTR_READY;
  logic              JUMP;
  logic [ADDR_W-1:0] JUMP_ADDR;
  logic              HALT_REQ;
  logic [ADDR_W-1:0] RAM_ADDRESS;
  logic              RAM_OPCODE;
  logic [DATA_W-1:0] INSTR;
  logic              INSTR_VALID;
  logic [ADDR_W-1:0] PC_OUT;
  logic              HALTED;

  logic [DATA_W-1:0] ram [2**ADDR_W];
  assign RAM_DATA = ram[RAM_ADDRESS];

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RUN         (RUN),
    .RAM_DATA    (RAM_DATA),
    .INSTR_READY (INSTR_READY),
    .JUMP        (JUMP),
    .JUMP_ADDR   (JUMP_ADDR),
    .HALT_REQ    (HALT_REQ),
    .RAM_ADDRESS (RAM_ADDRESS),
    .RAM_OPCODE  (RAM_OPCODE),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .PC_OUT      (PC_OUT),
    .HALTED      (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: fetch is either not started, halted, or counting down the
  // edges until the next instruction appears (2 = address phase pending,
  // 1 = data capture pending, 0 = instruction offered).
  // ---------------------------------------------------------------------------
  bit              m_started;
  bit              m_halted;
  int              m_wait;
  logic [ADDR_W-1:0] m_pc, m_mar;
  logic [DATA_W-1:0] m_ir;

  function automatic bit m_valid();
    return m_started && !m_halted && (m_wait == 0);
  endfunction

  task automatic model_edge();
    if (RST) begin
      m_started = 0; m_halted = 0; m_wait = 0;
      m_pc = '0; m_mar = '0; m_ir = '0;
    end else if (m_halted) begin
      // frozen
    end else if (!m_started) begin
      if (RUN) begin m_started = 1; m_wait = 2; end
    end else if (m_wait == 2) begin
      m_mar = m_pc; m_wait = 1;
    end else if (m_wait == 1) begin
      m_ir = ram[m_mar]; m_pc = m_pc + 1; m_wait = 0;
    end else if (INSTR_READY) begin
      if (HALT_REQ) m_halted = 1;
      else begin
        if (JUMP) m_pc = JUMP_ADDR;
        m_wait = 2;
      end
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare all outputs 1ns later. Inputs are changed only after this returns.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("ram_address", 16'(RAM_ADDRESS), 16'(m_mar));
    check("instr",       16'(INSTR),       16'(m_ir));
    check("pc_out",      16'(PC_OUT),      16'(m_pc));
    check("instr_valid", 16'(INSTR_VALID), 16'(m_valid()));
    check("halted",      16'(HALTED),      16'(m_halted));
    check("ram_opcode",  16'(RAM_OPCODE),  16'h0);
  endtask

  task automatic drive(input logic rst, input logic run, input logic rdy,
                       input logic jmp, input logic [ADDR_W-1:0] ja, input logic hlt);
    RST = rst; RUN = run; INSTR_READY = rdy; JUMP = jmp; JUMP_ADDR = ja; HALT_REQ = hlt;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!INSTR_VALID && n < 8) begin
      step();
      n++;
    end
    check(name, 16'(INSTR_VALID), 16'h1);
  endtask

  typedef struct {
    logic              rst, run, rdy, jmp, hlt;
    logic [ADDR_W-1:0] ja;
    logic              e_valid;
    logic [DATA_W-1:0] e_instr;
    logic [ADDR_W-1:0] e_pc;
    logic              e_halted;
  } vec_t;

  vec_t vecs [8];

  logic [ADDR_W-1:0] held_pc;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_instr;

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h1A;
    ram[1] = 8'h2B;
    drive(1, 0, 0, 0, '0, 0);

    // Reset then free-running fetch: valid after edges 3 and 6.
    vecs[0] = '{1, 0, 0, 0, 0, 4'h0, 0, 8'h00, 4'h0, 0};
    vecs[1] = '{0, 1, 1, 0, 0, 4'h0, 0, 8'h00, 4'h0, 0};
    vecs[2] = '{0, 1, 1, 0, 0, 4'h0, 0, 8'h00, 4'h0, 0};
    vecs[3] = '{0, 1, 1, 0, 0, 4'h0, 1, 8'h1A, 4'h1, 0};
    vecs[4] = '{0, 1, 1, 0, 0, 4'h0, 0, 8'h1A, 4'h1, 0};
    vecs[5] = '{0, 0, 1, 0, 0, 4'h0, 0, 8'h1A, 4'h1, 0};
    vecs[6] = '{0, 0, 1, 0, 0, 4'h0, 1, 8'h2B, 4'h2, 0};
    vecs[7] = '{0, 0, 0, 0, 0, 4'h0, 1, 8'h2B, 4'h2, 0};

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].rdy, vecs[i].jmp, vecs[i].ja, vecs[i].hlt);
      step();
      check($sformatf("vec%0d_valid", i),  16'(INSTR_VALID), 16'(vecs[i].e_valid));
      check($sformatf("vec%0d_instr", i),  16'(INSTR),       16'(vecs[i].e_instr));
      check($sformatf("vec%0d_pc", i),     16'(PC_OUT),      16'(vecs[i].e_pc));
      check($sformatf("vec%0d_halted", i), 16'(HALTED),      16'(vecs[i].e_halted));
    end

    // Backpressure: stalled in ISSUE with a jump offered, nothing moves.
    held_pc = PC_OUT; held_addr = RAM_ADDRESS; held_instr = INSTR;
    drive(0, 0, 0, 1, 4'h9, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 16'(INSTR_VALID), 16'h1);
      check("stall_instr", 16'(INSTR),       16'(held_instr));
      check("stall_pc",    16'(PC_OUT),      16'(held_pc));
      check("stall_addr",  16'(RAM_ADDRESS), 16'(held_addr));
    end

    // Jump to 0xC.
    ram[4'hC] = 8'h77;
    drive(0, 0, 1, 1, 4'hC, 0);
    step();
    drive(0, 0, 0, 0, 4'h0, 0);
    wait_valid("jump_wait");
    check("jump_instr", 16'(INSTR),  16'h77);
    check("jump_pc",    16'(PC_OUT), 16'hD);

    // Wrap: fetch from 0xF, PC rolls over to 0.
    ram[4'hF] = 8'h55;
    ram[4'h0] = 8'h66;
    drive(0, 0, 1, 1, 4'hF, 0);
    step();
    drive(0, 0, 0, 0, 4'h0, 0);
    wait_valid("wrap_wait1");
    check("wrap_instr1", 16'(INSTR),  16'h55);
    check("wrap_pc1",    16'(PC_OUT), 16'h0);
    drive(0, 0, 1, 0, 4'h0, 0);
    step();
    drive(0, 0, 0, 0, 4'h0, 0);
    wait_valid("wrap_wait2");
    check("wrap_instr2", 16'(INSTR),  16'h66);
    check("wrap_pc2",    16'(PC_OUT), 16'h1);

    // Halt beats jump; everything frozen afterwards.
    held_pc = PC_OUT;
    drive(0, 0, 1, 1, 4'h3, 1);
    step();
    check("halt_halted", 16'(HALTED),      16'h1);
    check("halt_valid",  16'(INSTR_VALID), 16'h0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
      step();
      check("halt_hold_pc",     16'(PC_OUT),      16'(held_pc));
      check("halt_hold_halted", 16'(HALTED),      16'h1);
      check("halt_hold_valid",  16'(INSTR_VALID), 16'h0);
    end

    // Reset out of HALT.
    drive(1, 0, 0, 0, 4'h0, 0);
    step();
    check("rst_halt_halted", 16'(HALTED),      16'h0);
    check("rst_halt_pc",     16'(PC_OUT),      16'h0);
    check("rst_halt_instr",  16'(INSTR),       16'h0);
    check("rst_halt_addr",   16'(RAM_ADDRESS), 16'h0);

    // Reset in the middle of a fetch (while in DATA).
    drive(0, 1, 1, 0, 4'h0, 0);
    step();
    drive(0, 0, 1, 0, 4'h0, 0);
    step();
    drive(1, 0, 1, 0, 4'h0, 0);
    step();
    drive(0, 0, 1, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_valid", 16'(INSTR_VALID), 16'h0);
      check("idle_pc",    16'(PC_OUT),      16'h0);
      check("idle_instr", 16'(INSTR),       16'h0);
    end

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0)
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = 8'($urandom);
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) == 0),
            1'($urandom),
            ($urandom_range(0, 2) == 0),
            4'($urandom),
            ($urandom_range(0, 15) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
